mtr_drv: RTL

Motor drive stage directly downstream of balance control. Converts the signed 12-bit `lft_spd`/`rght_spd` commands into complementary, non-overlapping 11-bit PWM pairs for the two H-bridges. Also monitors the bridge over-current comparators with a blanking window, and latches a shutdown after persistent over-current. Sits between balance control and the motor-driver pins.

---
 rtl/mtr_pkg.sv | 26 ++
 rtl/mtr_drv_side.sv | 74 +++++++
 rtl/mtr_drv.sv | 100 ++++++++++
 3 files changed

// File: rtl/mtr_pkg.sv
// Shared constants and types for the motor drive stage.
// Duty mapping helper turns a signed speed into an offset-binary PWM duty.
package mtr_pkg;

  localparam int PWM_W = 11;

  localparam logic [5:0]       NONOVERLAP_DEF = 6'd32;
  localparam logic [PWM_W-1:0] OVR_BLANK_DEF  = 11'd160;
  localparam logic [2:0]       OVR_LIMIT_DEF  = 3'd4;
  localparam logic [PWM_W-1:0] DUTY_ZERO      = 11'h400;

  typedef struct packed {
    logic pwm1;
    logic pwm2;
  } pwm_pair_t;

  // spd/2 + 1024: halve, keep 11 bits, flip the sign bit to offset binary
  function automatic logic [PWM_W-1:0] spd2duty(
    input logic signed [11:0] spd
  );
    logic signed [11:0] half;
    half = spd >>> 1;
    return PWM_W'(half) ^ DUTY_ZERO;
  endfunction

endpackage

// File: rtl/mtr_drv_side.sv
// One H-bridge side: duty latch, PWM compare, dead-time pair,
// over-current synchronizer and per-period over-current flag.
module pwm_side
  import mtr_pkg::*;
#(
  parameter logic [5:0]       NONOVERLAP = NONOVERLAP_DEF,
  parameter logic [PWM_W-1:0] OVR_BLANK  = OVR_BLANK_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PWM_W-1:0]  cnt,
  input  logic              wrap,
  input  logic              shtdwn_nxt,
  input  logic signed [11:0] spd,
  input  logic              ovr_i,
  output pwm_pair_t         pwm,
  output logic              ovr_hit
);

  logic [PWM_W-1:0] duty;
  logic             pwm_sig;
  logic             sig_nxt;
  logic             trans;
  logic [5:0]       dt;
  logic [5:0]       dt_nxt;
  logic             arm;
  logic [1:0]       sync;
  logic             ovr_seen;
  logic             ovr_evt;

  assign sig_nxt = cnt < duty;
  assign trans   = sig_nxt ^ pwm_sig;

  always_comb begin
    dt_nxt = dt;
    if (trans) begin
      dt_nxt = '0;
    end else if (dt != NONOVERLAP) begin
      dt_nxt = dt + 6'd1;
    end
  end

  // Outputs follow the raw PWM only once the dead time has fully elapsed
  assign arm = (dt_nxt == NONOVERLAP) & ~shtdwn_nxt;

  assign ovr_evt = sync[1] & pwm.pwm1 & (cnt >= OVR_BLANK);
  assign ovr_hit = ovr_seen | ovr_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty     <= DUTY_ZERO;
      pwm_sig  <= 1'b0;
      dt       <= '0;
      pwm      <= '0;
      sync     <= '0;
      ovr_seen <= 1'b0;
    end else begin
      if (wrap) begin
        duty <= spd2duty(spd);
      end
      pwm_sig  <= sig_nxt;
      dt       <= dt_nxt;
      pwm.pwm1 <= arm & sig_nxt;
      pwm.pwm2 <= arm & ~sig_nxt;
      sync     <= {sync[0], ovr_i};
      if (wrap) begin
        ovr_seen <= 1'b0;
      end else if (ovr_evt) begin
        ovr_seen <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mtr_drv.sv
// Motor drive stage: shared PWM period counter, two bridge sides,
// consecutive over-current period tracking and latched shutdown.
module mtr_drv
  import mtr_pkg::*;
#(
  parameter logic [5:0]       NONOVERLAP = NONOVERLAP_DEF,
  parameter logic [PWM_W-1:0] OVR_BLANK  = OVR_BLANK_DEF,
  parameter logic [2:0]       OVR_LIMIT  = OVR_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic               OVR_I_lft,
  input  logic               OVR_I_rght,
  output logic               PWM1_lft,
  output logic               PWM2_lft,
  output logic               PWM1_rght,
  output logic               PWM2_rght,
  output logic               PWM_synch,
  output logic               OVR_I_shtdwn
);

  logic [PWM_W-1:0] cnt;
  logic             wrap;
  logic [2:0]       ovr_periods;
  logic [2:0]       ovr_nxt;
  logic             shtdwn_nxt;
  logic             hit_l;
  logic             hit_r;
  pwm_pair_t        pl;
  pwm_pair_t        pr;

  assign wrap = &cnt;

  always_comb begin
    ovr_nxt = ovr_periods;
    if (wrap) begin
      if (hit_l | hit_r) begin
        ovr_nxt = (ovr_periods == 3'd7) ? 3'd7 : ovr_periods + 3'd1;
      end else begin
        ovr_nxt = '0;
      end
    end
  end

  // Next shutdown value gates the side output flops so the
  // PWM pins drop in the same cycle the flag rises
  assign shtdwn_nxt = OVR_I_shtdwn | (ovr_nxt >= OVR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      PWM_synch    <= 1'b0;
      ovr_periods  <= '0;
      OVR_I_shtdwn <= 1'b0;
    end else begin
      cnt          <= cnt + 11'd1;
      PWM_synch    <= wrap;
      ovr_periods  <= ovr_nxt;
      OVR_I_shtdwn <= shtdwn_nxt;
    end
  end

  pwm_side #(
    .NONOVERLAP (NONOVERLAP),
    .OVR_BLANK  (OVR_BLANK)
  ) u_lft (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt        (cnt),
    .wrap       (wrap),
    .shtdwn_nxt (shtdwn_nxt),
    .spd        (lft_spd),
    .ovr_i      (OVR_I_lft),
    .pwm        (pl),
    .ovr_hit    (hit_l)
  );

  pwm_side #(
    .NONOVERLAP (NONOVERLAP),
    .OVR_BLANK  (OVR_BLANK)
  ) u_rght (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt        (cnt),
    .wrap       (wrap),
    .shtdwn_nxt (shtdwn_nxt),
    .spd        (rght_spd),
    .ovr_i      (OVR_I_rght),
    .pwm        (pr),
    .ovr_hit    (hit_r)
  );

  assign PWM1_lft  = pl.pwm1;
  assign PWM2_lft  = pl.pwm2;
  assign PWM1_rght = pr.pwm1;
  assign PWM2_rght = pr.pwm2;

endmodule
